// File: rtl/chassis_frame_tx.sv
// Streams a 12-byte wheel-speed telemetry frame (hdr, len, 4x16-bit payload, sum)
// into a UART byte sender using its enable / busy handshake.
`timescale 1ns/1ps
module chassis_frame_tx #(
  parameter logic [7:0] HDR0         = 8'hAA,
  parameter logic [7:0] HDR1         = 8'h55,
  parameter int         GAP_CYCLES   = 217,
  parameter int         BUSY_TIMEOUT = 1024
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        frame_req,
  input  logic [15:0] wheel_spd0,
  input  logic [15:0] wheel_spd1,
  input  logic [15:0] wheel_spd2,
  input  logic [15:0] wheel_spd3,
  input  logic        tx_busy,
  output logic        uart_en,
  output logic [7:0]  uart_din,
  output logic        frame_busy,
  output logic        frame_done,
  output logic        tx_err
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(BUSY_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, STROBE, WAIT_DONE, GAP} state_t;

  state_t          state, state_nxt;
  logic [3:0][15:0] spd;
  logic [3:0]      byte_idx;
  logic [7:0]      chk, cur_byte;
  logic [TW-1:0]   to_cnt;
  logic [GW-1:0]   gap_cnt;
  logic            to_hit, gap_hit, last_byte, payload;

  assign to_hit    = (to_cnt == TO_LAST);
  assign gap_hit   = (gap_cnt == GAP_LAST);
  assign last_byte = (byte_idx == 4'd11);
  assign payload   = (byte_idx >= 4'd3) && (byte_idx <= 4'd10);

  always_comb begin
    cur_byte = chk;
    case (byte_idx)
      4'd0:    cur_byte = HDR0;
      4'd1:    cur_byte = HDR1;
      4'd2:    cur_byte = 8'h08;
      4'd3:    cur_byte = spd[0][15:8];
      4'd4:    cur_byte = spd[0][7:0];
      4'd5:    cur_byte = spd[1][15:8];
      4'd6:    cur_byte = spd[1][7:0];
      4'd7:    cur_byte = spd[2][15:8];
      4'd8:    cur_byte = spd[2][7:0];
      4'd9:    cur_byte = spd[3][15:8];
      4'd10:   cur_byte = spd[3][7:0];
      default: cur_byte = chk;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (frame_req) state_nxt = LOAD;
      LOAD:      state_nxt = STROBE;
      STROBE:    if (tx_busy) state_nxt = WAIT_DONE;
                 else if (to_hit) state_nxt = IDLE;
      WAIT_DONE: if (!tx_busy) state_nxt = GAP;
      GAP:       if (gap_hit) state_nxt = last_byte ? IDLE : LOAD;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      uart_en    <= 1'b0;
      uart_din   <= 8'h00;
      frame_busy <= 1'b0;
      frame_done <= 1'b0;
      tx_err     <= 1'b0;
      spd        <= '0;
      byte_idx   <= 4'd0;
      chk        <= 8'h00;
      to_cnt     <= '0;
      gap_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      frame_busy <= (state_nxt != IDLE);
      // enable is high only while in STROBE, so each byte gets a fresh rising edge
      uart_en    <= (state_nxt == STROBE);
      frame_done <= 1'b0;
      tx_err     <= 1'b0;
      case (state)
        IDLE: if (frame_req) begin
          spd      <= {wheel_spd3, wheel_spd2, wheel_spd1, wheel_spd0};
          byte_idx <= 4'd0;
        end
        LOAD: begin
          uart_din <= cur_byte;
          to_cnt   <= '0;
          if (byte_idx == 4'd0) chk <= 8'h00;
          else if (payload)     chk <= chk + cur_byte;
        end
        STROBE: begin
          to_cnt <= to_cnt + 1'b1;
          if (!tx_busy && to_hit) tx_err <= 1'b1;
        end
        WAIT_DONE: gap_cnt <= '0;
        GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_hit) begin
            if (last_byte) frame_done <= 1'b1;
            else           byte_idx   <= byte_idx + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
